// File: rtl/terminal_arbiter.sv
// terminal_arbiter: round-robin write master for the 80x30 terminal buffer with a hardware clear engine
module terminal_arbiter #(
    parameter logic [11:0] ADDR_MAX   = 12'd2399,
    parameter logic [7:0]  CLEAR_CHAR = 8'h20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_req,
    output logic        clear_busy,
    input  logic        req0_valid,
    input  logic [11:0] req0_addr,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [11:0] req1_addr,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic [11:0] terminal_addr,
    output logic        terminal_write,
    output logic [7:0]  terminal_data,
    output logic        addr_error
);
    typedef enum logic {ARB, CLEAR} state_t;

    state_t      state, state_next;
    logic        prio;
    logic [11:0] count;
    logic        grant0, grant1, xfer, in_range;
    logic [11:0] sel_addr;
    logic [7:0]  sel_data;

    // readies never look at the requester's own valid, so a requester can present and be accepted in one cycle
    always_comb begin
        req0_ready = (state == ARB) & ~clear_req & (~prio | ~req1_valid);
        req1_ready = (state == ARB) & ~clear_req & (prio | ~req0_valid);
        grant0     = req0_valid & req0_ready;
        grant1     = req1_valid & req1_ready;
        xfer       = grant0 | grant1;
        sel_addr   = grant0 ? req0_addr : req1_addr;
        sel_data   = grant0 ? req0_data : req1_data;
        in_range   = sel_addr <= ADDR_MAX;
        clear_busy = state == CLEAR;
        state_next = (state == ARB) ? (clear_req ? CLEAR : ARB) : (count == ADDR_MAX ? ARB : CLEAR);
    end

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ARB;
        else state <= state_next;
    end

    // output registers, sweep counter, priority pointer and sticky address error
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            terminal_addr  <= '0;
            terminal_data  <= '0;
            terminal_write <= 1'b0;
            addr_error     <= 1'b0;
            prio           <= 1'b0;
            count          <= '0;
        end else if (state == CLEAR) begin
            terminal_addr  <= count;
            terminal_data  <= CLEAR_CHAR;
            terminal_write <= 1'b1;
            count          <= count + 12'd1;
        end else if (clear_req) begin
            terminal_write <= 1'b0;
            count          <= '0;
        end else if (xfer) begin
            terminal_write <= in_range;
            if (in_range) begin
                terminal_addr <= sel_addr;
                terminal_data <= sel_data;
            end else begin
                addr_error <= 1'b1;
            end
            prio <= grant0;
        end else begin
            terminal_write <= 1'b0;
        end
    end
endmodule

// File: tb/tb_terminal_arbiter.sv
// tb_terminal_arbiter: vector table, corner sequences and random stimulus against a behavioural model
module tb_terminal_arbiter;
    logic        clock, reset, clear_req, clear_busy;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [11:0] req0_addr, req1_addr, terminal_addr;
    logic [7:0]  req0_data, req1_data, terminal_data;
    logic        terminal_write, addr_error;

    terminal_arbiter dut (
        .clock(clock), .reset(reset), .clear_req(clear_req), .clear_busy(clear_busy),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .terminal_addr(terminal_addr), .terminal_write(terminal_write), .terminal_data(terminal_data),
        .addr_error(addr_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    // model: clear_left counts remaining sweep writes, clear_idx the next cell to fill
    logic        m_prio, m_we, m_err;
    logic [11:0] m_addr;
    logic [7:0]  m_data;
    int          m_left, m_idx;

    typedef struct {
        logic v0; logic [11:0] a0; logic [7:0] d0;
        logic v1; logic [11:0] a1; logic [7:0] d1;
        logic r0; logic r1;
        logic we; logic [11:0] addr; logic [7:0] data; logic err;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", n, act, exp, $time);
        end
    endtask

    task automatic model_reset;
        m_prio = 0; m_we = 0; m_err = 0; m_addr = 0; m_data = 0; m_left = 0; m_idx = 0;
    endtask

    task automatic do_reset;
        reset = 1; clear_req = 0; req0_valid = 0; req1_valid = 0;
        req0_addr = 0; req1_addr = 0; req0_data = 0; req1_data = 0;
        #1;
        chk("rst_write", 32'(terminal_write), 0);
        chk("rst_addr", 32'(terminal_addr), 0);
        chk("rst_data", 32'(terminal_data), 0);
        chk("rst_busy", 32'(clear_busy), 0);
        chk("rst_err", 32'(addr_error), 0);
        @(negedge clock);
        reset = 0;
        model_reset();
        @(posedge clock);
        #1;
    endtask

    // one clock cycle: called at posedge+1, returns at the next posedge+1
    task automatic cyc(input logic v0, input logic [11:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [11:0] a1, input logic [7:0] d1,
                       input logic cr, output logic r0s, output logic r1s);
        logic e_r0, e_r1, g0;
        logic [11:0] a;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        clear_req = cr;
        #2;
        e_r0 = (m_left == 0) && !cr && (!m_prio || !v1);
        e_r1 = (m_left == 0) && !cr && (m_prio || !v0);
        r0s = req0_ready; r1s = req1_ready;
        chk("req0_ready", 32'(req0_ready), 32'(e_r0));
        chk("req1_ready", 32'(req1_ready), 32'(e_r1));
        chk("busy_pre", 32'(clear_busy), 32'(m_left > 0));
        if (m_left > 0) begin
            m_we = 1; m_addr = 12'(m_idx); m_data = 8'h20; m_idx++; m_left--;
        end else if (cr) begin
            m_we = 0; m_left = 2400; m_idx = 0;
        end else if ((v0 && e_r0) || (v1 && e_r1)) begin
            g0 = v0 && e_r0;
            a = g0 ? a0 : a1;
            if (a <= 12'd2399) begin
                m_we = 1; m_addr = a; m_data = g0 ? d0 : d1;
            end else begin
                m_we = 0; m_err = 1;
            end
            m_prio = g0;
        end else begin
            m_we = 0;
        end
        @(posedge clock);
        #1;
        chk("terminal_write", 32'(terminal_write), 32'(m_we));
        chk("terminal_addr", 32'(terminal_addr), 32'(m_addr));
        chk("terminal_data", 32'(terminal_data), 32'(m_data));
        chk("addr_error", 32'(addr_error), 32'(m_err));
        chk("clear_busy", 32'(clear_busy), 32'(m_left > 0));
    endtask

    task automatic idle(input logic v0, input logic cr);
        logic x0, x1;
        cyc(v0, 12'd3, 8'h30, 1'b0, 12'd0, 8'h00, cr, x0, x1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r0s, r1s;
        int writes, busy;
        //          v0  a0       d0     v1  a1        d1     r0 r1 we addr      data   err
        tbl[0] = '{1, 12'd5,    8'h41, 0, 12'd0,    8'h00, 1, 0, 1, 12'd5,    8'h41, 0};
        tbl[1] = '{1, 12'd10,   8'h42, 1, 12'd20,   8'h43, 0, 1, 1, 12'd20,   8'h43, 0};
        tbl[2] = '{1, 12'd10,   8'h42, 1, 12'd20,   8'h43, 1, 0, 1, 12'd10,   8'h42, 0};
        tbl[3] = '{1, 12'd10,   8'h42, 1, 12'd20,   8'h43, 0, 1, 1, 12'd20,   8'h43, 0};
        tbl[4] = '{1, 12'd7,    8'h45, 0, 12'd0,    8'h00, 1, 0, 1, 12'd7,    8'h45, 0};
        tbl[5] = '{0, 12'd0,    8'h00, 1, 12'd2400, 8'h44, 0, 1, 0, 12'd7,    8'h45, 1};
        tbl[6] = '{1, 12'd2399, 8'h46, 1, 12'd1,    8'h47, 1, 0, 1, 12'd2399, 8'h46, 1};
        tbl[7] = '{0, 12'd0,    8'h00, 0, 12'd0,    8'h00, 1, 1, 0, 12'd2399, 8'h46, 1};

        reset = 1; clear_req = 0; req0_valid = 0; req1_valid = 0;
        req0_addr = 0; req1_addr = 0; req0_data = 0; req1_data = 0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, 1'b0, r0s, r1s);
            chk($sformatf("vec%0d_r0", i), 32'(r0s), 32'(tbl[i].r0));
            chk($sformatf("vec%0d_r1", i), 32'(r1s), 32'(tbl[i].r1));
            chk($sformatf("vec%0d_we", i), 32'(terminal_write), 32'(tbl[i].we));
            chk($sformatf("vec%0d_addr", i), 32'(terminal_addr), 32'(tbl[i].addr));
            chk($sformatf("vec%0d_data", i), 32'(terminal_data), 32'(tbl[i].data));
            chk($sformatf("vec%0d_err", i), 32'(addr_error), 32'(tbl[i].err));
        end

        idle(1'b1, 1'b0);
        chk("pre_async_write", 32'(terminal_write), 1);
        do_reset();

        idle(1'b1, 1'b1);
        writes = 0; busy = clear_busy ? 1 : 0;
        for (int i = 0; i < 2400; i++) begin
            idle(1'b1, i == 1000);
            if (terminal_write && terminal_data == 8'h20) writes++;
            if (clear_busy) busy++;
        end
        chk("clear_writes", 32'(writes), 2400);
        chk("clear_busy_cycles", 32'(busy), 2400);
        idle(1'b1, 1'b0);
        chk("post_clear_accept", 32'(terminal_addr), 3);
        for (int i = 0; i < 4; i++) idle(1'b0, 1'b0);
        chk("post_clear_idle", 32'(terminal_write), 0);

        do_reset();
        idle(1'b0, 1'b1);
        repeat (1000) idle(1'b0, 1'b0);
        chk("mid_clear_addr", 32'(terminal_addr), 999);
        do_reset();
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        chk("restart_addr0", 32'(terminal_addr), 0);
        writes = 1;
        for (int i = 0; i < 2400; i++) begin
            idle(1'b0, 1'b0);
            if (terminal_write && terminal_data == 8'h20) writes++;
        end
        chk("restart_writes", 32'(writes), 2400);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] a0, a1;
            a0 = ($urandom_range(0, 7) == 0) ? 12'(2400 + $urandom_range(0, 1695)) : 12'($urandom_range(0, 2399));
            a1 = ($urandom_range(0, 7) == 0) ? 12'(2400 + $urandom_range(0, 1695)) : 12'($urandom_range(0, 2399));
            cyc(1'($urandom_range(0, 3) != 0), a0, 8'($urandom),
                1'($urandom_range(0, 3) != 0), a1, 8'($urandom),
                1'($urandom_range(0, 299) == 0), r0s, r1s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
